// File: rtl/free_list.sv
// rtl/free_list.sv - circular free list of physical register tags for rename/retire
//
// Purpose:
//   A circular FIFO of free physical register tags. Dispatch receives up to
//   three new tags per cycle. Retire returns up to three freed Told tags per
//   cycle. A branch-mispredict recovery restores the head to a value that
//   retire supplies.
//
// Ports:
//   clock          clock
//   reset          synchronous, active-high
//   DispatchEN     per-slot allocation request (slot 2 oldest)
//   Pregs          allocated tag per slot (combinational, 0 when slot idle)
//   Pregs_valid    per-slot grant
//   free_num       min(count, 3)
//   Retire_EN      per-slot retire enable (slot 2 oldest)
//   Tolds_in       freed tags from retire; tag 0 is never pushed
//   BPRecoverEN    mispredict recovery pulse
//   BPRecoverHead  head value to restore on recovery
//   FreelistHead   current head pointer
//   fl_error       sticky consistency error
//
// Optional feature macro: FREELIST_CHECK_EN
//   When the macro is defined, the consistency checker drives fl_error.
//   When the macro is undefined, fl_error is tied to 0.

module free_list #(
  parameter int FL_SIZE  = 32,
  parameter int PR_W     = 6,
  parameter int FL_PTR_W = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2:0]          DispatchEN,
  output logic [3*PR_W-1:0]   Pregs,
  output logic [2:0]          Pregs_valid,
  output logic [1:0]          free_num,
  input  logic [2:0]          Retire_EN,
  input  logic [3*PR_W-1:0]   Tolds_in,
  input  logic                BPRecoverEN,
  input  logic [FL_PTR_W-1:0] BPRecoverHead,
  output logic [FL_PTR_W-1:0] FreelistHead,
  output logic                fl_error
);

  localparam int               CNT_W = FL_PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(FL_SIZE);

  logic [PR_W-1:0]     r_entries [FL_SIZE];
  logic [FL_PTR_W-1:0] r_head;
  logic [FL_PTR_W-1:0] r_tail;
  logic [CNT_W-1:0]    r_count;

  logic [1:0]          w_pops;
  logic [1:0]          w_pushes;
  logic [CNT_W-1:0]    w_space;
  logic                w_we    [3];
  logic [FL_PTR_W-1:0] w_waddr [3];
  logic [PR_W-1:0]     w_wdata [3];
  logic [FL_PTR_W-1:0] w_tail_next;

  assign w_space      = FULL - r_count;
  assign w_tail_next  = r_tail + FL_PTR_W'(w_pushes);
  assign free_num     = (r_count >= CNT_W'(3)) ? 2'd3 : r_count[1:0];
  assign FreelistHead = r_head;

  // Grants are handed out oldest slot first. The k-th enabled slot reads
  // entries[head+k]. Recovery suppresses every grant for that cycle.
  always_comb begin : alloc
    Pregs       = '0;
    Pregs_valid = '0;
    w_pops      = '0;
    for (int s = 2; s >= 0; s--) begin
      if (DispatchEN[s] && !BPRecoverEN && (CNT_W'(w_pops) < r_count)) begin
        Pregs_valid[s]        = 1'b1;
        Pregs[s*PR_W +: PR_W] = r_entries[r_head + FL_PTR_W'(w_pops)];
        w_pops                = w_pops + 2'd1;
      end
    end
  end

  // Freed tags are packed into consecutive tail slots, oldest slot first.
  // Outside recovery, the list only accepts as many pushes as it has free
  // room at the start of the cycle. Same-cycle pops do not make room.
  // During recovery, the count is forced back to full, so pushes always land.
  always_comb begin : release_path
    w_pushes = '0;
    for (int j = 0; j < 3; j++) begin
      w_we[j]    = 1'b0;
      w_waddr[j] = '0;
      w_wdata[j] = '0;
    end
    for (int s = 2; s >= 0; s--) begin
      if (Retire_EN[s] && (Tolds_in[s*PR_W +: PR_W] != '0) &&
          (BPRecoverEN || (CNT_W'(w_pushes) < w_space))) begin
        w_we[w_pushes]    = 1'b1;
        w_waddr[w_pushes] = r_tail + FL_PTR_W'(w_pushes);
        w_wdata[w_pushes] = Tolds_in[s*PR_W +: PR_W];
        w_pushes          = w_pushes + 2'd1;
      end
    end
  end

  always_ff @(posedge clock) begin : pointers
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= FULL;
    end else begin
      r_tail <= w_tail_next;
      if (BPRecoverEN) begin
        r_head  <= BPRecoverHead;
        r_count <= FULL;
      end else begin
        r_head  <= r_head + FL_PTR_W'(w_pops);
        r_count <= r_count + CNT_W'(w_pushes) - CNT_W'(w_pops);
      end
    end
  end

  always_ff @(posedge clock) begin : storage
    if (reset) begin
      for (int i = 0; i < FL_SIZE; i++) begin
        r_entries[i] <= PR_W'(FL_SIZE + i);
      end
    end else begin
      for (int j = 0; j < 3; j++) begin
        if (w_we[j]) begin
          r_entries[w_waddr[j]] <= w_wdata[j];
        end
      end
    end
  end

`ifdef FREELIST_CHECK_EN
  logic [1:0] w_push_req;
  logic       w_drop;
  logic       w_bad_en;
  logic       w_bad_recover;
  logic       r_fl_error;

  always_comb begin : push_requests
    w_push_req = '0;
    for (int s = 0; s < 3; s++) begin
      if (Retire_EN[s] && (Tolds_in[s*PR_W +: PR_W] != '0)) begin
        w_push_req = w_push_req + 2'd1;
      end
    end
  end

  // Retire must enable slots contiguously from the oldest slot.
  assign w_drop        = !BPRecoverEN && (w_push_req != w_pushes);
  assign w_bad_en      = !(Retire_EN inside {3'b000, 3'b100, 3'b110, 3'b111});
  assign w_bad_recover = BPRecoverEN && (w_tail_next != BPRecoverHead);

  always_ff @(posedge clock) begin : checker
    if (reset) begin
      r_fl_error <= 1'b0;
    end else if (w_drop || w_bad_en || w_bad_recover) begin
      r_fl_error <= 1'b1;
    end
  end

  assign fl_error = r_fl_error;
`else
  assign fl_error = 1'b0;
`endif

endmodule
